// File: rtl/sched_pkg.sv
// Shared types and constants for the periodic task scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sched_pkg;

  // Grant FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } sched_state_e;

  // Watchdog limit, in cycles spent in WAIT_DONE without the granted task's i_done
  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/clock_enable_divider.sv
// Divides the source clock enable down to the scheduler tick.
// Latency: o_tick is combinational, high on every par_ce_divisor-th i_ce_mhz pulse.
// Backpressure: none; advances only while i_ce_mhz pulses.
module clock_enable_divider #(
  parameter int par_ce_divisor = 1000
) (
  input  logic i_clk_mhz,
  input  logic i_rst_mhz,
  input  logic i_ce_mhz,
  output logic o_tick
);

  localparam int            CW   = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
  localparam logic [CW-1:0] LAST = CW'(par_ce_divisor - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = i_ce_mhz && (cnt_q == LAST);

  // Advance on each source enable, wrapping after the last pulse of a tick period
  always_comb begin
    cnt_d = cnt_q;
    if (i_ce_mhz) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Source-enable pulse counter
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

endmodule

// File: rtl/periodic_task_scheduler.sv
// Periodic task scheduler: per-task tick counters raise requests, a round-robin FSM grants one at a time.
// Latency: o_start rises 1 cycle after IDLE sees a pending request; consecutive grants are >= 3 cycles apart.
// Backpressure: a grant is held until the granted task's i_done; a request is single-deep, extra ones set o_overrun.
// Build option SCHED_WATCHDOG_EN: 16-bit WAIT_DONE timeout that abandons the grant and flags overrun.
module periodic_task_scheduler
  import sched_pkg::*;
#(
  parameter int par_ce_divisor   = 1000,
  parameter int par_task_count   = 3,
  parameter int par_period_width = 16
) (
  input  logic                                       i_clk_mhz,
  input  logic                                       i_rst_mhz,
  input  logic                                       i_ce_mhz,
  input  logic [par_task_count-1:0]                  i_enable,
  input  logic [par_task_count*par_period_width-1:0] i_period,
  input  logic [par_task_count-1:0]                  i_done,
  output logic [par_task_count-1:0]                  o_start,
  output logic                                       o_busy,
  output logic [2:0]                                 o_grant_idx,
  output logic [par_task_count-1:0]                  o_overrun
);

  localparam int N = par_task_count;
  localparam int W = par_period_width;

  logic         tick;
  logic [W-1:0] cnt_q [N];
  logic [W-1:0] cnt_d [N];
  logic [N-1:0] wrap;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] overrun_q, overrun_d;
  logic [N-1:0] grant_clr;
  logic [N-1:0] start_q;
  logic         busy_q;
  logic [2:0]   grant_q;
  logic [2:0]   sel_idx;
  logic         sel_vld;
  logic         done_hit;
  logic         wd_fire;
  sched_state_e state_q;

  clock_enable_divider #(
    .par_ce_divisor(par_ce_divisor)
  ) u_ce_div (
    .i_clk_mhz(i_clk_mhz),
    .i_rst_mhz(i_rst_mhz),
    .i_ce_mhz (i_ce_mhz),
    .o_tick   (tick)
  );

  // Task counters: count ticks and wrap at max(period,1)-1; a counter already past a
  // shortened period wraps on its next tick
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
      wrap[k]  = 1'b0;
      if (!i_enable[k]) begin
        cnt_d[k] = '0;
      end else if (tick) begin
        if (({1'b0, cnt_q[k]} + (W+1)'(1)) >= {1'b0, i_period[k*W +: W]}) begin
          cnt_d[k] = '0;
          wrap[k]  = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + W'(1);
        end
      end
    end
  end

  // Round-robin pick: lowest pending index above the last grant, else lowest at or below it
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = grant_q;
    done_hit  = 1'b0;
    grant_clr = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (pending_q[k] && (k <= int'(grant_q))) begin
        sel_vld = 1'b1;
        sel_idx = 3'(k);
      end
    end
    for (int k = N-1; k >= 0; k--) begin
      if (pending_q[k] && (k > int'(grant_q))) begin
        sel_vld = 1'b1;
        sel_idx = 3'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      done_hit     = done_hit | (i_done[k] && (grant_q == 3'(k)));
      grant_clr[k] = (state_q == ST_IDLE) && sel_vld && (sel_idx == 3'(k));
    end
  end

  // Request bookkeeping: a wrap beats a same-cycle grant clear; wraps on an already
  // requested or currently granted task are recorded as sticky overruns
  always_comb begin
    for (int k = 0; k < N; k++) begin
      if (!i_enable[k])      pending_d[k] = 1'b0;
      else if (wrap[k])      pending_d[k] = 1'b1;
      else if (grant_clr[k]) pending_d[k] = 1'b0;
      else                   pending_d[k] = pending_q[k];
      overrun_d[k] = overrun_q[k]
                   | (wrap[k] && (pending_q[k] || (busy_q && (grant_q == 3'(k)))))
                   | (wd_fire && (grant_q == 3'(k)));
    end
  end

  // Counter, request and overrun state
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Grant FSM with registered start, busy and grant index
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      state_q <= ST_IDLE;
      grant_q <= 3'(N-1);
      start_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (sel_vld) begin
            state_q <= ST_START;
            grant_q <= sel_idx;
            start_q <= grant_clr;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (done_hit || wd_fire) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic [15:0] wd_cnt_q;

  // Count cycles spent waiting for the granted task's completion
  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz || (state_q != ST_WAIT_DONE)) wd_cnt_q <= '0;
    else                                        wd_cnt_q <= wd_cnt_q + 16'd1;
  end

  // Fires on the 65535th waiting cycle; an i_done on that same cycle still wins
  assign wd_fire = (state_q == ST_WAIT_DONE) && !done_hit && (wd_cnt_q == (WD_LIMIT - 16'd1));
`else
  assign wd_fire = 1'b0;
`endif

  assign o_start     = start_q;
  assign o_busy      = busy_q;
  assign o_grant_idx = grant_q;
  assign o_overrun   = overrun_q;

endmodule
